// File: rtl/sdram_sched_pkg.sv
// ============================================================================
// sdram_sched_pkg : command codes, scheduler states and buffer index type
// Revision 1.0
// ============================================================================
`default_nettype none

package sdram_sched_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef logic [1:0] buf_idx_t;

endpackage

`default_nettype wire

// File: rtl/triple_buffer_rotator.sv
// ============================================================================
// triple_buffer_rotator : write/read/spare frame indices plus the fresh flag
// Revision 1.0
// ============================================================================
`default_nettype none

module triple_buffer_rotator
    import sdram_sched_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       write_frame_done_i,
    input  logic       read_frame_done_i,
    output logic [1:0] write_buffer_o,
    output logic [1:0] read_buffer_o
);

    buf_idx_t write_q, write_d;
    buf_idx_t read_q,  read_d;
    buf_idx_t spare_q, spare_d;
    logic     fresh_q, fresh_d;

    always_comb begin
        write_d = write_q;
        read_d  = read_q;
        spare_d = spare_q;
        fresh_d = fresh_q;
        if (write_frame_done_i) begin
            write_d = spare_q;
            spare_d = write_q;
            fresh_d = 1'b1;
        end else if (read_frame_done_i && fresh_q) begin
            // Only hand the display a frame the camera has completely written.
            read_d  = spare_q;
            spare_d = read_q;
            fresh_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            write_q <= 2'd0;
            read_q  <= 2'd1;
            spare_q <= 2'd2;
            fresh_q <= 1'b0;
        end else begin
            write_q <= write_d;
            read_q  <= read_d;
            spare_q <= spare_d;
            fresh_q <= fresh_d;
        end
    end

    assign write_buffer_o = write_q;
    assign read_buffer_o  = read_q;

endmodule

`default_nettype wire

// File: rtl/sdram_burst_scheduler.sv
// ============================================================================
// sdram_burst_scheduler : watermark-driven read/write burst arbiter with
// bounded write deferral and triple-buffered linear frame addressing
// Revision 1.0
// ============================================================================
`default_nettype none

module sdram_burst_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 22,
    parameter int POINTER_WIDTH   = 6,
    parameter int BURST_LENGTH    = 8,
    parameter int FRAME_WORDS     = 153600,
    parameter int MAX_WRITE_DEFER = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [POINTER_WIDTH-1:0] write_fifo_used_i,
    input  logic [POINTER_WIDTH-1:0] read_fifo_used_i,
    input  logic                     data_write_done_i,
    input  logic                     data_read_valid_i,
    output logic [1:0]               command_o,
    output logic [ADDRESS_WIDTH-1:0] data_address_o,
    output logic                     write_fifo_acknowledge_o,
    output logic                     read_fifo_enable_o,
    output logic                     write_frame_done_o,
    output logic                     read_frame_done_o,
    output logic [1:0]               write_buffer_o,
    output logic [1:0]               read_buffer_o
);

    localparam int BEAT_W  = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
    localparam int DEFER_W = $clog2(MAX_WRITE_DEFER + 1);

    localparam logic [ADDRESS_WIDTH-1:0] c_BURST_LEN = ADDRESS_WIDTH'(BURST_LENGTH);
    localparam logic [ADDRESS_WIDTH-1:0] c_FRAME     = ADDRESS_WIDTH'(FRAME_WORDS);
    localparam logic [ADDRESS_WIDTH-1:0] c_BASE2     = ADDRESS_WIDTH'(2 * FRAME_WORDS);
    localparam logic [BEAT_W-1:0]        c_LAST_BEAT = BEAT_W'(BURST_LENGTH - 1);
    localparam logic [DEFER_W-1:0]       c_MAX_DEFER = DEFER_W'(MAX_WRITE_DEFER);

    state_t                   state_q, state_d;
    logic [1:0]               command_q, command_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [DEFER_W-1:0]       defer_q, defer_d;
    logic [ADDRESS_WIDTH-1:0] wr_off_q, wr_off_d;
    logic [ADDRESS_WIDTH-1:0] rd_off_q, rd_off_d;
    logic                     wr_frame_q, rd_frame_q;

    logic                     write_ok, read_ok;
    logic                     write_wrap, read_wrap;
    logic [ADDRESS_WIDTH-1:0] wr_off_next, rd_off_next;
    logic                     unused_lsbs;

    // Base addresses come from a constant mux rather than a multiplier.
    function automatic logic [ADDRESS_WIDTH-1:0] base_of(input buf_idx_t idx);
        case (idx)
            2'd1:    base_of = c_FRAME;
            2'd2:    base_of = c_BASE2;
            default: base_of = '0;
        endcase
    endfunction

    assign write_ok    = write_fifo_used_i[POINTER_WIDTH-1];
    assign read_ok     = !read_fifo_used_i[POINTER_WIDTH-1];
    assign unused_lsbs = ^{write_fifo_used_i[POINTER_WIDTH-2:0], read_fifo_used_i[POINTER_WIDTH-2:0]};
    assign wr_off_next = wr_off_q + c_BURST_LEN;
    assign rd_off_next = rd_off_q + c_BURST_LEN;

    always_comb begin
        state_d    = state_q;
        command_d  = command_q;
        address_d  = address_q;
        beat_d     = beat_q;
        defer_d    = defer_q;
        wr_off_d   = wr_off_q;
        rd_off_d   = rd_off_q;
        write_wrap = 1'b0;
        read_wrap  = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_ok && (!write_ok || (defer_q < c_MAX_DEFER))) begin
                    state_d   = READ;
                    command_d = CMD_READ;
                    address_d = base_of(read_buffer_o) + rd_off_q;
                    defer_d   = write_ok ? (defer_q + DEFER_W'(1)) : '0;
                end else if (write_ok) begin
                    state_d   = WRITE;
                    command_d = CMD_WRITE;
                    address_d = base_of(write_buffer_o) + wr_off_q;
                    defer_d   = '0;
                end
            end
            READ: begin
                if (data_read_valid_i) begin
                    if (beat_q == c_LAST_BEAT) begin
                        beat_d    = '0;
                        state_d   = IDLE;
                        command_d = CMD_IDLE;
                        read_wrap = (rd_off_next == c_FRAME);
                        rd_off_d  = read_wrap ? '0 : rd_off_next;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            WRITE: begin
                if (data_write_done_i) begin
                    if (beat_q == c_LAST_BEAT) begin
                        beat_d     = '0;
                        state_d    = IDLE;
                        command_d  = CMD_IDLE;
                        write_wrap = (wr_off_next == c_FRAME);
                        wr_off_d   = write_wrap ? '0 : wr_off_next;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                command_d = CMD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            command_q  <= CMD_IDLE;
            address_q  <= '0;
            beat_q     <= '0;
            defer_q    <= '0;
            wr_off_q   <= '0;
            rd_off_q   <= '0;
            wr_frame_q <= 1'b0;
            rd_frame_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            command_q  <= command_d;
            address_q  <= address_d;
            beat_q     <= beat_d;
            defer_q    <= defer_d;
            wr_off_q   <= wr_off_d;
            rd_off_q   <= rd_off_d;
            wr_frame_q <= write_wrap;
            rd_frame_q <= read_wrap;
        end
    end

    // Rotation is driven by the wrap itself so new indices are in place for the next grant.
    triple_buffer_rotator u_rotator (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .write_frame_done_i (write_wrap),
        .read_frame_done_i  (read_wrap),
        .write_buffer_o     (write_buffer_o),
        .read_buffer_o      (read_buffer_o)
    );

    assign command_o                = command_q;
    assign data_address_o           = address_q;
    assign write_fifo_acknowledge_o = (command_q == CMD_WRITE) && data_write_done_i;
    assign read_fifo_enable_o       = (command_q == CMD_READ) && data_read_valid_i;
    assign write_frame_done_o       = wr_frame_q;
    assign read_frame_done_o        = rd_frame_q;

endmodule

`default_nettype wire

// File: doc/sdram_burst_scheduler.md
Name: sdram_burst_scheduler

Overview:
Single-clock scheduler that shares one SDRAM controller between a camera write FIFO and a display read FIFO. It issues fixed-length read and write bursts based on FIFO watermarks, and bounds how long a pending write can be deferred. It generates linear frame addresses and rotates three frame buffers so the display never reads a frame that is still being written. It sits between the CDC FIFOs and the SDRAM controller's command/data_address interface.

Parameters:
ADDRESS_WIDTH, 22, SDRAM word address width.
POINTER_WIDTH, 6, FIFO occupancy width; the MSB is the half-full watermark.
BURST_LENGTH, 8, beats per burst; power of two; FRAME_WORDS must be a multiple of it.
FRAME_WORDS, 153600, 16-bit words per frame (640x480 RAW8 / 2); 3*FRAME_WORDS < 2**ADDRESS_WIDTH.
MAX_WRITE_DEFER, 4, maximum consecutive read grants allowed while a write is eligible.

Ports:
clk  input  1  SDRAM-domain clock
reset  input  1  asynchronous, active-high reset
write_fifo_used  input  POINTER_WIDTH  camera FIFO occupancy (sdram domain)
read_fifo_used  input  POINTER_WIDTH  display FIFO occupancy (sdram domain)
data_write_done  input  1  controller accepted one write beat
data_read_valid  input  1  controller returned one read beat
command  output  2  0 idle, 1 write, 2 read; to controller
data_address  output  ADDRESS_WIDTH  burst start address; to controller
write_fifo_acknowledge  output  1  pop camera FIFO (show-ahead)
read_fifo_enable  output  1  push read beat into display FIFO
write_frame_done  output  1  one-cycle pulse when a full frame is written
read_frame_done  output  1  one-cycle pulse when a full frame is read
write_buffer  output  2  buffer index being written (0..2)
read_buffer  output  2  buffer index being read (0..2)

Behaviour:
- Reset (async, active-high): state IDLE, command 0, data_address 0, beat/defer counters 0, both offsets 0, write_buffer 0, read_buffer 1, spare 2, fresh 0, pulses 0. Reset mid-burst abandons the burst; the controller is reset together with this block.
- Eligibility, evaluated in IDLE only:
  - read_ok = !read_fifo_used[MSB]
  - write_ok = write_fifo_used[MSB]
- IDLE:
  - If read_ok and (!write_ok or defer < MAX_WRITE_DEFER): go to READ; command<=2; data_address<=base(read_buffer)+read_offset; defer<=defer+1 if write_ok, else 0.
  - Else if write_ok: go to WRITE; command<=1; data_address<=base(write_buffer)+write_offset; defer<=0.
  - Else stay IDLE; command stays 0; data_address holds.
  - Grant latency is 1 cycle from eligibility to command change.
- READ: each data_read_valid increments beat. When beat==BURST_LENGTH-1 and data_read_valid: beat<=0, state IDLE, command<=0, read_offset advances by BURST_LENGTH.
- WRITE: same rule, counting data_write_done and advancing write_offset.
- Combinational outputs:
  - write_fifo_acknowledge = (command==1) && data_write_done
  - read_fifo_enable = (command==2) && data_read_valid
  - Beats arriving while command==0 are ignored, so no acknowledge is generated.
- Wrap: when offset+BURST_LENGTH==FRAME_WORDS, offset<=0 and the frame-done event fires. Arithmetic is ADDRESS_WIDTH wide. base(i)=i*FRAME_WORDS, taken from a constant mux; no multiplier.
- Write frame done: write_frame_done pulses; swap write_buffer and spare; fresh<=1.
- Read frame done: read_frame_done pulses; if fresh, swap read_buffer and spare and set fresh<=0. Otherwise the same buffer is re-read (repeat frame).
- Write and read frame-done cannot coincide because only one burst is active at a time. Rotation takes effect before the next grant.
- Invariant: write_buffer, read_buffer and spare are always distinct.
- Back-to-back bursts: at least one IDLE cycle between bursts.

Decomposition:
- Package sdram_sched_pkg:
  - command constants CMD_IDLE=2'd0, CMD_WRITE=2'd1, CMD_READ=2'd2
  - state enum {IDLE, READ, WRITE}
  - buffer index typedef (logic [1:0])
- Sub-module triple_buffer_rotator: holds write/read/spare indices and the fresh flag.
  - Inputs: write_frame_done, read_frame_done.
  - Outputs: indices; one instance.

Test Plan:
(All with FRAME_WORDS=32, BURST_LENGTH=8.)
- Only write_fifo_used=32 -> command=1 next cycle, data_address=0; after 8 data_write_done pulses: 8 acknowledges, command=0, next write address 8.
- Both eligible continuously -> 4 read grants, then 1 write grant, then reads resume; defer never exceeds 4.
- Four write bursts -> write_frame_done pulses once; write_buffer becomes 2, spare 0, write address returns to 2*32=64.
- Read 4 bursts with fresh=1 -> read_buffer becomes 0 and the next read starts at 0. With fresh=0 -> read_buffer stays 1 and the next read starts at 32.
- data_read_valid/data_write_done pulsed while IDLE -> no read_fifo_enable or write_fifo_acknowledge, counters unchanged.
- Assert reset after 3 write beats -> command=0 immediately (asynchronous); after release, the write restarts at address 0 with buffers 0/1/2.
